// File: rtl/wb_block_master.sv
// wb_block_master: bus initiator that fills or copies a block of words over
// the word-addressed io_bus_* protocol, one single-word transaction at a time.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   io_cmd_start          one-cycle command strobe (honoured only when idle)
//   io_cmd_copy           1 = copy src->dst, 0 = fill dst with io_cmd_value
//   io_cmd_src/dst        start addresses, latched at start
//   io_cmd_len            word count (0 is legal, completes without bus cycles)
//   io_cmd_value          fill word
//   io_cmd_abort          terminate the running command
//   io_busy/done/error    status: busy level, end-of-command pulse, sticky timeout
//   io_bus_*              bus side: addr, dat2 (write data), dat4 (read data),
//                         sel, we, ack (idles high, low for the execute cycle)
module wb_block_master #(
    parameter int unsigned ADDR_STEP = 1,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_cmd_start,
    input  logic        io_cmd_copy,
    input  logic [31:0] io_cmd_src,
    input  logic [31:0] io_cmd_dst,
    input  logic [15:0] io_cmd_len,
    input  logic [31:0] io_cmd_value,
    input  logic        io_cmd_abort,
    output logic        io_busy,
    output logic        io_done,
    output logic        io_error,
    output logic [31:0] io_bus_addr,
    output logic [31:0] io_bus_dat2,
    input  logic [31:0] io_bus_dat4,
    output logic        io_bus_sel,
    output logic        io_bus_we,
    input  logic        io_bus_ack
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_GAP,
        S_WR,
        S_WR_GAP
    } state_t;

    state_t          state_q, state_d;
    logic            copy_q, copy_d;
    logic [AW-1:0]   src_q, src_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [LW-1:0]   remain_q, remain_d;
    logic [DW-1:0]   value_q, value_d;
    logic [DW-1:0]   rbuf_q, rbuf_d;
    logic            seen_low_q, seen_low_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   dat2_q, dat2_d;
    logic            sel_q, sel_d;
    logic            we_q, we_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic            phase_done;
    logic            timeout_hit;

    // A phase only completes on ack high after ack was seen low, since ack idles high.
    assign phase_done  = io_bus_ack & seen_low_q;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            copy_q     <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            remain_q   <= '0;
            value_q    <= '0;
            rbuf_q     <= '0;
            seen_low_q <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            dat2_q     <= '0;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            copy_q     <= copy_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            remain_q   <= remain_d;
            value_q    <= value_d;
            rbuf_q     <= rbuf_d;
            seen_low_q <= seen_low_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            dat2_q     <= dat2_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        copy_d     = copy_q;
        src_d      = src_q;
        dst_d      = dst_q;
        remain_d   = remain_q;
        value_d    = value_q;
        rbuf_d     = rbuf_q;
        seen_low_d = seen_low_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        dat2_d     = dat2_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;

        case (state_q)
            S_IDLE: begin
                // Start wins over a simultaneous abort; abort alone is a no-op here.
                if (io_cmd_start) begin
                    copy_d     = io_cmd_copy;
                    src_d      = io_cmd_src;
                    dst_d      = io_cmd_dst;
                    remain_d   = io_cmd_len;
                    value_d    = io_cmd_value;
                    error_d    = 1'b0;
                    seen_low_d = 1'b0;
                    cnt_d      = '0;
                    if (io_cmd_len != '0) begin
                        busy_d  = 1'b1;
                        state_d = io_cmd_copy ? S_RD : S_WR;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RD, S_WR: begin
                // Priority: abort, then completion, then timeout.
                if (io_cmd_abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (phase_done) begin
                    if (state_q == S_RD) begin
                        rbuf_d  = io_bus_dat4;
                        state_d = S_RD_GAP;
                    end else begin
                        state_d = S_WR_GAP;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    seen_low_d = seen_low_q | (sel_q & ~io_bus_ack);
                    cnt_d      = cnt_q + CW'(1);
                end
            end
            S_RD_GAP: begin
                if (io_cmd_abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d    = S_WR;
                    seen_low_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            S_WR_GAP: begin
                if (io_cmd_abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // Pointers wrap silently modulo 2^32.
                    remain_d   = remain_q - LW'(1);
                    src_d      = src_q + AW'(ADDR_STEP);
                    dst_d      = dst_q + AW'(ADDR_STEP);
                    seen_low_d = 1'b0;
                    cnt_d      = '0;
                    if (remain_q == LW'(1)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = copy_q ? S_RD : S_WR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Bus outputs follow the next state so sel rises on the entry edge.
        sel_d = (state_d == S_RD) || (state_d == S_WR);
        we_d  = (state_d == S_WR);
        if (state_d == S_RD) begin
            addr_d = src_d;
        end else if (state_d == S_WR) begin
            addr_d = dst_d;
            dat2_d = copy_d ? rbuf_d : value_d;
        end
    end

    assign io_busy     = busy_q;
    assign io_done     = done_q;
    assign io_error    = error_q;
    assign io_bus_addr = addr_q;
    assign io_bus_dat2 = dat2_q;
    assign io_bus_sel  = sel_q;
    assign io_bus_we   = we_q;

endmodule

// File: tb/tb_wb_block_master.sv
// Directed bench for wb_block_master with a registered memory responder
// (latches on sel, ack low for one cycle, re-arms once sel drops).
module tb_wb_block_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_cmd_start;
    logic        io_cmd_copy;
    logic [31:0] io_cmd_src;
    logic [31:0] io_cmd_dst;
    logic [15:0] io_cmd_len;
    logic [31:0] io_cmd_value;
    logic        io_cmd_abort;
    logic        io_busy;
    logic        io_done;
    logic        io_error;
    logic [31:0] io_bus_addr;
    logic [31:0] io_bus_dat2;
    logic [31:0] io_bus_dat4;
    logic        io_bus_sel;
    logic        io_bus_we;
    logic        io_bus_ack;

    logic        ack_stuck;
    logic        armed;
    logic [31:0] mem    [0:255];
    logic [31:0] wr_log [0:63];
    int          wr_cnt      = 0;
    int          sel_cycles  = 0;
    int          done_pulses = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_block_master #(.ADDR_STEP(1), .TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .io_cmd_start(io_cmd_start),
        .io_cmd_copy (io_cmd_copy),
        .io_cmd_src  (io_cmd_src),
        .io_cmd_dst  (io_cmd_dst),
        .io_cmd_len  (io_cmd_len),
        .io_cmd_value(io_cmd_value),
        .io_cmd_abort(io_cmd_abort),
        .io_busy     (io_busy),
        .io_done     (io_done),
        .io_error    (io_error),
        .io_bus_addr (io_bus_addr),
        .io_bus_dat2 (io_bus_dat2),
        .io_bus_dat4 (io_bus_dat4),
        .io_bus_sel  (io_bus_sel),
        .io_bus_we   (io_bus_we),
        .io_bus_ack  (io_bus_ack)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'(i + 1) * 32'h1111;
    endfunction

    // Memory responder.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_bus_ack  <= 1'b1;
            armed       <= 1'b1;
            io_bus_dat4 <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (ack_stuck) begin
            io_bus_ack <= 1'b1;
        end else if (io_bus_sel && armed && io_bus_ack) begin
            io_bus_ack <= 1'b0;
            armed      <= 1'b0;
            if (io_bus_we) begin
                mem[io_bus_addr[7:0]] <= io_bus_dat2;
                wr_log[wr_cnt % 64]   <= io_bus_addr;
                wr_cnt                <= wr_cnt + 1;
            end else begin
                io_bus_dat4 <= mem[io_bus_addr[7:0]];
            end
        end else if (!io_bus_ack) begin
            io_bus_ack <= 1'b1;
        end else if (!io_bus_sel) begin
            armed <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (io_bus_sel) sel_cycles <= sel_cycles + 1;
        if (io_done) done_pulses <= done_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the start cycle.
    task automatic start_cmd(input logic copy, input logic [31:0] src, input logic [31:0] dst,
                             input logic [15:0] len, input logic [31:0] val);
        io_cmd_start = 1'b1;
        io_cmd_copy  = copy;
        io_cmd_src   = src;
        io_cmd_dst   = dst;
        io_cmd_len   = len;
        io_cmd_value = val;
        @(negedge clk);
        io_cmd_start = 1'b0;
    endtask

    // Cycles from the current negedge until io_done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (io_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int wc0;
        int sc0;
        int dc0;

        reset        = 1'b0;
        io_cmd_start = 1'b0;
        io_cmd_copy  = 1'b0;
        io_cmd_src   = '0;
        io_cmd_dst   = '0;
        io_cmd_len   = '0;
        io_cmd_value = '0;
        io_cmd_abort = 1'b0;
        ack_stuck    = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_sel",   32'(io_bus_sel), 32'd0);
        check("rst_we",    32'(io_bus_we),  32'd0);
        check("rst_busy",  32'(io_busy),    32'd0);
        check("rst_done",  32'(io_done),    32'd0);
        check("rst_error", 32'(io_error),   32'd0);
        check("rst_addr",  io_bus_addr,     32'd0);
        check("rst_dat2",  io_bus_dat2,     32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Fill dst=0x10, len=3, value=0x0741.
        start_cmd(1'b0, 32'h0, 32'h10, 16'd3, 32'h0741);
        check("fill_first_sel",  32'(io_bus_sel), 32'd1);
        check("fill_first_we",   32'(io_bus_we),  32'd1);
        check("fill_first_addr", io_bus_addr,     32'h10);
        check("fill_first_dat2", io_bus_dat2,     32'h0741);
        check("fill_busy",       32'(io_busy),    32'd1);
        wait_done(n);
        check("fill_done_latency", 32'(n), 32'd12);
        @(negedge clk);
        check("fill_busy_after", 32'(io_busy), 32'd0);
        check("fill_done_pulse", 32'(io_done), 32'd0);
        check("fill_mem10", mem[8'h10], 32'h0741);
        check("fill_mem11", mem[8'h11], 32'h0741);
        check("fill_mem12", mem[8'h12], 32'h0741);
        check("fill_mem13", mem[8'h13], 32'h0001_5554);

        // Copy src=0, dst=0x50, len=2.
        wc0 = wr_cnt;
        start_cmd(1'b1, 32'h0, 32'h50, 16'd2, 32'h0);
        check("copy_first_we",   32'(io_bus_we), 32'd0);
        check("copy_first_addr", io_bus_addr,    32'h0);
        wait_done(n);
        check("copy_done_latency", 32'(n), 32'd16);
        check("copy_error", 32'(io_error), 32'd0);
        @(negedge clk);
        check("copy_mem50", mem[8'h50], 32'h1111);
        check("copy_mem51", mem[8'h51], 32'h2222);
        check("copy_writes", 32'(wr_cnt - wc0), 32'd2);

        // len=0: done next cycle, no bus cycle.
        sc0 = sel_cycles;
        start_cmd(1'b0, 32'h0, 32'h90, 16'd0, 32'h1);
        check("len0_done", 32'(io_done), 32'd1);
        check("len0_busy", 32'(io_busy), 32'd0);
        repeat (3) @(negedge clk);
        check("len0_no_sel", 32'(sel_cycles - sc0), 32'd0);
        check("len0_mem90",  mem[8'h90], init_word(8'h90));

        // Start while busy is ignored.
        wc0 = wr_cnt;
        start_cmd(1'b0, 32'h0, 32'h20, 16'd2, 32'hAAAA);
        repeat (2) @(negedge clk);
        start_cmd(1'b0, 32'h0, 32'h30, 16'd5, 32'hBBBB);
        wait_done(n);
        @(negedge clk);
        check("busy_start_writes", 32'(wr_cnt - wc0), 32'd2);
        check("busy_start_mem21",  mem[8'h21], 32'hAAAA);
        check("busy_start_mem30",  mem[8'h30], init_word(8'h30));
        check("busy_start_idle",   32'(io_busy), 32'd0);

        // Timeout with ack stuck high.
        ack_stuck = 1'b1;
        dc0 = done_pulses;
        start_cmd(1'b0, 32'h0, 32'h40, 16'd1, 32'hCCCC);
        n = 0;
        while (io_bus_sel === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_sel_cycles", 32'(n), 32'd8);
        check("to_done",  32'(io_done),  32'd1);
        check("to_error", 32'(io_error), 32'd1);
        @(negedge clk);
        check("to_done_once", 32'(io_done), 32'd0);
        check("to_busy",      32'(io_busy), 32'd0);
        check("to_error_sticky", 32'(io_error), 32'd1);
        repeat (2) @(negedge clk);
        check("to_done_count", 32'(done_pulses - dc0), 32'd1);
        check("to_mem40", mem[8'h40], init_word(8'h40));
        ack_stuck = 1'b0;
        start_cmd(1'b0, 32'h0, 32'h0, 16'd0, 32'h0);
        check("to_error_cleared", 32'(io_error), 32'd0);
        @(negedge clk);

        // Abort during second WR of a len=4 fill.
        start_cmd(1'b0, 32'h0, 32'h60, 16'd4, 32'h5A5A);
        repeat (4) @(negedge clk);
        check("abort_wr2_sel",  32'(io_bus_sel), 32'd1);
        check("abort_wr2_addr", io_bus_addr,     32'h61);
        io_cmd_abort = 1'b1;
        @(negedge clk);
        io_cmd_abort = 1'b0;
        check("abort_sel",   32'(io_bus_sel), 32'd0);
        check("abort_done",  32'(io_done),    32'd1);
        check("abort_busy",  32'(io_busy),    32'd0);
        check("abort_error", 32'(io_error),   32'd0);
        repeat (3) @(negedge clk);
        check("abort_mem60", mem[8'h60], 32'h5A5A);
        check("abort_mem61", mem[8'h61], 32'h5A5A);
        check("abort_mem62", mem[8'h62], init_word(8'h62));

        // Asynchronous reset mid-RD.
        dc0 = done_pulses;
        start_cmd(1'b1, 32'h0, 32'h70, 16'd1, 32'h0);
        check("rrd_sel", 32'(io_bus_sel), 32'd1);
        check("rrd_we",  32'(io_bus_we),  32'd0);
        #2 reset = 1'b0;
        #1;
        check("rrd_async_sel",  32'(io_bus_sel), 32'd0);
        check("rrd_async_busy", 32'(io_busy),    32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rrd_no_done", 32'(done_pulses - dc0), 32'd0);
        check("rrd_idle_sel", 32'(io_bus_sel), 32'd0);

        // Destination address wrap.
        wc0 = wr_cnt;
        start_cmd(1'b0, 32'h0, 32'hFFFF_FFFF, 16'd2, 32'h77);
        check("wrap_first_addr", io_bus_addr, 32'hFFFF_FFFF);
        wait_done(n);
        check("wrap_done_latency", 32'(n), 32'd8);
        check("wrap_writes", 32'(wr_cnt - wc0), 32'd2);
        check("wrap_log0", wr_log[wc0 % 64],       32'hFFFF_FFFF);
        check("wrap_log1", wr_log[(wc0 + 1) % 64], 32'h0000_0000);
        check("wrap_mem00", mem[8'h00], 32'h77);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
